inv_share_arb: RTL

INV_SHARE_ARB -- requirements
Module: inv_share_arb

---
 rtl/inv_share_pkg.sv | 20 ++
 rtl/inv_share_arb_rr_pick.sv | 31 +++
 rtl/inv_share_arb.sv | 93 +++++++++
 3 files changed

// File: rtl/inv_share_pkg.sv
// Shared definitions for the inv_share_arb slice: FSM encoding, default sizes
// and the requester-index width helper.
package inv_share_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  // A single requester still needs a 1-bit index port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_N_REQ);

endpackage

// File: rtl/inv_share_arb_rr_pick.sv
// rr_pick: combinational round-robin selector. Scans req starting one past
// last_id, wrapping modulo N_REQ, and reports the first set index.
module rr_pick
  import inv_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [ID_W-1:0]  pick,
  output logic             found
);

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % N_REQ);
  endfunction

  // Offset N_REQ lands back on last_id, so it only wins when it is the sole requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!found && req[wrap_add(last_id, off)]) begin
        pick  = wrap_add(last_id, off);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_share_arb.sv
// inv_share_arb: round-robin arbiter in front of one shared registered inverter.
// Optional feature macro INV_SHARE_OP_CNT_EN adds a saturating 16-bit op_cnt output.
module inv_share_arb
  import inv_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [ID_W-1:0]        dout_id
`ifdef INV_SHARE_OP_CNT_EN
  ,
  output logic [15:0]            op_cnt
`endif
);

  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

  state_t           state, next_state;
  logic [ID_W-1:0]  last_id;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic [WIDTH-1:0] operand;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .pick    (pick),
    .found   (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ISSUE;
      ISSUE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // last_id doubles as the in-flight owner, since it only moves on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      operand <= '0;
      last_id <= LAST_INIT;
    end else if (state == IDLE && found) begin
      gnt     <= ONE_HOT0 << pick;
      operand <= din[pick*WIDTH +: WIDTH];
      last_id <= pick;
    end else begin
      gnt     <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_id    <= '0;
    end else if (state == ISSUE) begin
      dout       <= ~operand;
      dout_valid <= 1'b1;
      dout_id    <= last_id;
    end else begin
      dout_valid <= 1'b0;
    end
  end

`ifdef INV_SHARE_OP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     op_cnt <= '0;
    else if (state == ISSUE && op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
  end
`endif

endmodule
